// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel push-button conditioner.
// Each raw button level goes through a flip-flop synchroniser. The press and
// the release are then both debounced with a per-channel stability counter.
// The block drives a registered level, one-cycle press and release pulses,
// and a toggle level that flips on every accepted press. Every output is
// registered in the clk domain.
module multi_debouncer #(
  parameter int N_CH        = 5,
  parameter int CNT_W       = 16,
  parameter int STABLE_CNT  = 65535,  // 1 .. 2**CNT_W-1
  parameter int SYNC_STAGES = 2       // >= 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   btn_in,
  input  logic [N_CH-1:0]   toggle_clr,
  output logic [N_CH-1:0]   btn_state,
  output logic [N_CH-1:0]   btn_press,
  output logic [N_CH-1:0]   btn_release,
  output logic [N_CH-1:0]   btn_toggle
);

  // Terminal count: a mismatch seen with the counter at this value is the
  // STABLE_CNT-th consecutive one, so the change is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  sync;
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [N_CH-1:0]  differ;
  logic [N_CH-1:0]  at_last;
  logic [N_CH-1:0]  accept;
  logic [N_CH-1:0]  press_now;

  assign sync = sync_q[SYNC_STAGES-1];

  // Per-channel decode of the counter: mismatch, terminal count, acceptance.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      differ[i]  = sync[i] ^ btn_state[i];
      at_last[i] = (cnt_q[i] == CNT_LAST);
    end
  end

  assign accept    = differ & at_last;
  assign press_now = accept & sync;

  // Synchroniser chain for the asynchronous raw button levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= btn_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Stability counters. A single matching sample restarts the count, and
  // the count is cleared again on acceptance, so it never passes CNT_LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!differ[i] || at_last[i]) cnt_q[i] <= '0;
        else                          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounced level and the one-cycle pulses. Both are registered on the
  // acceptance edge, so the pulses line up with the level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_state   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btn_state   <= btn_state ^ accept;
      btn_press   <= press_now;
      btn_release <= accept & ~sync;
    end
  end

  // Toggle level. It flips on the same edge that raises btn_press. A clear
  // on that edge takes priority over the flip.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_toggle <= '0;
    end else begin
      btn_toggle <= (btn_toggle ^ press_now) & ~toggle_clr;
    end
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Testbench for multi_debouncer (N_CH=2, STABLE_CNT=4, SYNC_STAGES=2).
// The reference model keeps the last STABLE_CNT synchronised samples of each
// channel. It accepts a change when all of those samples differ from the
// current debounced level.
module tb_multi_debouncer;

  localparam int N_CH = 2;
  localparam int ST   = 4;

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] toggle_clr;
  logic [N_CH-1:0] btn_state;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] btn_toggle;

  int n_cmp  = 0;
  int n_fail = 0;

  multi_debouncer #(
    .N_CH(N_CH), .CNT_W(16), .STABLE_CNT(ST), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .toggle_clr(toggle_clr),
    .btn_state(btn_state), .btn_press(btn_press),
    .btn_release(btn_release), .btn_toggle(btn_toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [N_CH-1:0] m_p0, m_p1;
  logic [N_CH-1:0] m_hist [ST-1];
  logic [N_CH-1:0] m_acc;
  logic [N_CH-1:0] exp_state, exp_press, exp_rel, exp_tog;

  wire [4*N_CH-1:0] dut_vec = {btn_state, btn_press, btn_release, btn_toggle};
  wire [4*N_CH-1:0] exp_vec = {exp_state, exp_press, exp_rel, exp_tog};

  always_comb begin
    m_acc = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_acc[c] = (m_p1[c] != exp_state[c]);
      for (int h = 0; h < ST-1; h++)
        if (m_hist[h][c] == exp_state[c]) m_acc[c] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_p0 <= '0; m_p1 <= '0;
      for (int h = 0; h < ST-1; h++) m_hist[h] <= '0;
      exp_state <= '0; exp_press <= '0; exp_rel <= '0; exp_tog <= '0;
    end else begin
      exp_state <= exp_state ^ m_acc;
      exp_press <= m_acc & m_p1;
      exp_rel   <= m_acc & ~m_p1;
      exp_tog   <= (exp_tog ^ (m_acc & m_p1)) & ~toggle_clr;
      m_hist[0] <= m_p1;
      for (int h = 1; h < ST-1; h++) m_hist[h] <= m_hist[h-1];
      m_p1 <= m_p0;
      m_p0 <= btn_in;
    end
  end

  task automatic test_reset();
    rst = 1'b1; btn_in = 2'b11; toggle_clr = 2'b00;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== '0) begin
        n_fail++; $display("FAIL reset_outputs actual=%b required=%b", dut_vec, 8'b0);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL model_reset k=%0d actual=%b required=%b", k, dut_vec, exp_vec);
      end
      n_cmp++;
      if (k < 6 && btn_state[0] !== 1'b0) begin
        n_fail++; $display("FAIL reset_latency_early k=%0d actual=%b required=0", k, btn_state[0]);
      end else if (k == 6 && {btn_state[0], btn_press[0]} !== 2'b11) begin
        n_fail++; $display("FAIL reset_latency_edge6 actual=%b required=11", {btn_state[0], btn_press[0]});
      end else if (k > 6 && btn_press[0] !== 1'b0) begin
        n_fail++; $display("FAIL reset_press_width k=%0d actual=%b required=0", k, btn_press[0]);
      end
    end
  endtask

  task automatic test_glitch();
    btn_in = 2'b00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL model_glitch_rel k=%0d actual=%b required=%b", k, dut_vec, exp_vec);
      end
    end
    for (int r = 0; r < 5; r++) begin
      for (int ph = 0; ph < 3; ph++) begin
        btn_in[0] = (ph != 2);
        @(negedge clk);
        n_cmp++;
        if ({btn_state[0], btn_press[0], btn_release[0]} !== 3'b000) begin
          n_fail++; $display("FAIL glitch_reject r=%0d actual=%b required=000", r,
                              {btn_state[0], btn_press[0], btn_release[0]});
        end
      end
    end
    btn_in[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL model_glitch k=%0d actual=%b required=%b", k, dut_vec, exp_vec);
      end
      n_cmp++;
      if (btn_press[0] !== (k == 6)) begin
        n_fail++; $display("FAIL glitch_hold_press k=%0d actual=%b required=%b", k, btn_press[0], (k == 6));
      end
    end
  endtask

  task automatic test_release();
    btn_in[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL model_release k=%0d actual=%b required=%b", k, dut_vec, exp_vec);
      end
      n_cmp++;
      if ({btn_state[0], btn_press[0], btn_release[0]} !== ((k < 6) ? 3'b100 : (k == 6) ? 3'b001 : 3'b000)) begin
        n_fail++; $display("FAIL release_seq k=%0d actual=%b", k, {btn_state[0], btn_press[0], btn_release[0]});
      end
    end
  endtask

  task automatic test_toggle();
    toggle_clr = 2'b01;
    @(negedge clk);
    toggle_clr = 2'b00;
    n_cmp++;
    if (btn_toggle[0] !== 1'b0) begin
      n_fail++; $display("FAIL toggle_clear actual=%b required=0", btn_toggle[0]);
    end
    for (int rep = 0; rep < 2; rep++) begin
      btn_in[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        n_cmp++;
        if (btn_toggle[0] !== ((k >= 6) ? (rep == 0) : (rep == 1))) begin
          n_fail++; $display("FAIL toggle_press rep=%0d k=%0d actual=%b", rep, k, btn_toggle[0]);
        end
      end
      btn_in[0] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        n_cmp++;
        if (btn_toggle[0] !== (rep == 0)) begin
          n_fail++; $display("FAIL toggle_release rep=%0d k=%0d actual=%b required=%b", rep, k, btn_toggle[0], (rep == 0));
        end
        n_cmp++;
        if (dut_vec !== exp_vec) begin
          n_fail++; $display("FAIL model_toggle k=%0d actual=%b required=%b", k, dut_vec, exp_vec);
        end
      end
    end
  endtask

  task automatic test_clr_on_press();
    btn_in = 2'b11;
    for (int k = 1; k <= 7; k++) begin
      toggle_clr = (k == 6) ? 2'b01 : 2'b00;
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL model_clr k=%0d actual=%b required=%b", k, dut_vec, exp_vec);
      end
      if (k == 6) begin
        n_cmp++;
        if ({btn_press, btn_toggle[0]} !== 3'b110) begin
          n_fail++; $display("FAIL clr_on_press actual=%b required=110", {btn_press, btn_toggle[0]});
        end
      end
    end
    toggle_clr = 2'b00;
  endtask

  task automatic test_reset_mid();
    btn_in = 2'b10;
    repeat (4) @(negedge clk);
    rst = 1'b1; btn_in = 2'b11;
    @(negedge clk);
    n_cmp++;
    if (dut_vec !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs actual=%b required=%b", dut_vec, 8'b0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL model_reset_mid k=%0d actual=%b required=%b", k, dut_vec, exp_vec);
      end
      n_cmp++;
      if (btn_state !== ((k >= 6) ? 2'b11 : 2'b00)) begin
        n_fail++; $display("FAIL reset_mid_latency k=%0d actual=%b", k, btn_state);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 7) == 0) btn_in[c] = ~btn_in[c];
      toggle_clr = ($urandom_range(0, 19) == 0) ? N_CH'($urandom_range(0, 3)) : '0;
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_fail++; $display("FAIL model_random k=%0d actual=%b required=%b", k, dut_vec, exp_vec);
      end
      n_cmp++;
      if ((btn_press & btn_release) !== '0) begin
        n_fail++; $display("FAIL random_pulse_excl k=%0d actual=%b required=00", k, btn_press & btn_release);
      end
    end
    rst = 1'b0; toggle_clr = '0;
  endtask

  initial begin
    rst = 1'b1; btn_in = '0; toggle_clr = '0;
    test_reset();
    test_glitch();
    test_release();
    test_toggle();
    test_clr_on_press();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
